pc_sequencer: RTL and testbench

Next-PC controller for the 32-bit MIPS fetch stage. It drives the `PC_Next` and `w_en` inputs of the PC register, and reads the PC register's `PCResult` output back. Each cycle it picks one of: sequential fetch, branch/jump redirect, exception vector or hold. Redirects that arrive while instruction memory is busy are buffered until memory accepts them. It also produces the pipeline flush strobes, the exception return address and a redirect performance counter.

---
 rtl/pc_sequencer.sv | 125 ++++++++++++
 tb/tb_pc_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Next-PC controller for the MIPS fetch stage: chooses sequential, redirect,
// exception or hold, and buffers redirects while instruction memory is busy.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] PCResult,
  input  logic        imem_ready,
  input  logic        hazard_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exception,
  output logic [31:0] PC_Next,
  output logic        w_en,
  output logic        flush_if,
  output logic        flush_id,
  output logic [31:0] epc,
  output logic [15:0] redirect_count
);

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

  state_t          state;
  state_t          state_d;
  logic [AW-1:0]   pending;
  logic [AW-1:0]   pending_d;
  logic [AW-1:0]   epc_d;
  logic [AW-1:0]   pc_next_raw;
  logic [AW-1:0]   target;
  logic            redirect;

  // Redirect target in RUN, by priority: exception, branch, jump.
  always_comb begin
    target = jump_target;
    if (exception)         target = EXC_VECTOR;
    else if (branch_taken) target = branch_target;
  end

  // Next-state and combinational PC-register controls.
  always_comb begin
    state_d     = state;
    pending_d   = pending;
    epc_d       = epc;
    pc_next_raw = PCResult;
    w_en        = 1'b0;
    flush_if    = 1'b0;
    flush_id    = 1'b0;
    redirect    = 1'b0;

    if (Reset) begin
      pc_next_raw = RESET_VECTOR;
    end else begin
      case (state)
        BOOT: begin
          pc_next_raw = RESET_VECTOR;
          w_en        = 1'b1;
          state_d     = RUN;
        end
        RUN: begin
          if (exception || branch_taken || jump) begin
            redirect = 1'b1;
            flush_if = 1'b1;
            flush_id = exception || branch_taken;
            if (exception) epc_d = PCResult;
            if (imem_ready) begin
              pc_next_raw = target;
              w_en        = 1'b1;
            end else begin
              pending_d = target;
              state_d   = PEND;
            end
          end else if (!hazard_stall && imem_ready) begin
            pc_next_raw = PCResult + AW'(4);
            w_en        = 1'b1;
          end
        end
        PEND: begin
          // Branch/jump/stall here come from squashed instructions.
          if (exception) begin
            redirect  = 1'b1;
            flush_if  = 1'b1;
            flush_id  = 1'b1;
            epc_d     = pending;
            pending_d = EXC_VECTOR;
            if (imem_ready) begin
              pc_next_raw = EXC_VECTOR;
              w_en        = 1'b1;
              state_d     = RUN;
            end
          end else if (imem_ready) begin
            pc_next_raw = pending;
            w_en        = 1'b1;
            state_d     = RUN;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  assign PC_Next = pc_next_raw & ~AW'(3);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state          <= BOOT;
      pending        <= '0;
      epc            <= '0;
      redirect_count <= '0;
    end else begin
      state   <= state_d;
      pending <= pending_d;
      epc     <= epc_d;
      if (redirect && (redirect_count != {CW{1'b1}}))
        redirect_count <= redirect_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural PC register closing the loop.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] PCResult;
  logic        imem_ready;
  logic        hazard_stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        exception;
  logic [31:0] PC_Next;
  logic        w_en;
  logic        flush_if;
  logic        flush_id;
  logic [31:0] epc;
  logic [15:0] redirect_count;

  int checks   = 0;
  int failures = 0;

  pc_sequencer dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .PCResult      (PCResult),
    .imem_ready    (imem_ready),
    .hazard_stall  (hazard_stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .exception     (exception),
    .PC_Next       (PC_Next),
    .w_en          (w_en),
    .flush_if      (flush_if),
    .flush_id      (flush_id),
    .epc           (epc),
    .redirect_count(redirect_count)
  );

  always #5 CLK = ~CLK;

  // PC register the sequencer drives; arbitrary power-up value.
  logic [31:0] pc_reg = 32'hDEAD_BEEC;
  always @(posedge CLK) if (w_en) pc_reg <= PC_Next;
  assign PCResult = pc_reg;

  typedef struct {
    logic        rst, rdy, stall, br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        exc;
    logic [31:0] pn;
    logic        we, fi, fd;
    logic [31:0] pc, ep;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs[NV];

  function automatic vec_t mk(logic rst, logic rdy, logic stall, logic br, logic [31:0] bt,
                              logic jmp, logic [31:0] jt, logic exc, logic [31:0] pn,
                              logic we, logic fi, logic fd, logic [31:0] pc,
                              logic [31:0] ep, logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.stall = stall; v.br = br; v.bt = bt;
    v.jmp = jmp; v.jt = jt; v.exc = exc; v.pn = pn;
    v.we = we; v.fi = fi; v.fd = fd; v.pc = pc; v.ep = ep; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic stall, input logic br,
                       input logic [31:0] bt, input logic jmp, input logic [31:0] jt,
                       input logic exc);
    Reset = rst; imem_ready = rdy; hazard_stall = stall; branch_taken = br;
    branch_target = bt; jump = jmp; jump_target = jt; exception = exc;
  endtask

  localparam logic [31:0] EXC = 32'h8000_0180;
  localparam logic [31:0] P0  = 32'hDEAD_BEEC;

  initial begin
    int pulses;
    int waited;
    drive(1, 1, 0, 0, 0, 0, 0, 0);

    //            rst rdy stl br bt         jmp jt            exc PC_Next       we fi fd pc_after      epc        cnt
    vecs[0]  = mk(1, 1, 0, 0, 0,          0, 0,            0,  32'h0,        0, 0, 0, P0,           32'h0,     16'd0);
    vecs[1]  = mk(1, 1, 0, 0, 0,          0, 0,            0,  32'h0,        0, 0, 0, P0,           32'h0,     16'd0);
    vecs[2]  = mk(0, 1, 0, 0, 0,          0, 0,            0,  32'h0,        1, 0, 0, 32'h0,        32'h0,     16'd0);
    vecs[3]  = mk(0, 1, 0, 0, 0,          0, 0,            0,  32'h4,        1, 0, 0, 32'h4,        32'h0,     16'd0);
    vecs[4]  = mk(0, 1, 0, 0, 0,          0, 0,            0,  32'h8,        1, 0, 0, 32'h8,        32'h0,     16'd0);
    vecs[5]  = mk(0, 1, 0, 0, 0,          1, 32'h40,       0,  32'h40,       1, 1, 0, 32'h40,       32'h0,     16'd1);
    // branch beats stall
    vecs[6]  = mk(0, 1, 1, 1, 32'h100,    0, 0,            0,  32'h100,      1, 1, 1, 32'h100,      32'h0,     16'd2);
    vecs[7]  = mk(0, 1, 0, 0, 0,          0, 0,            0,  32'h104,      1, 0, 0, 32'h104,      32'h0,     16'd2);
    vecs[8]  = mk(0, 1, 1, 0, 0,          0, 0,            0,  32'h104,      0, 0, 0, 32'h104,      32'h0,     16'd2);
    vecs[9]  = mk(0, 0, 0, 0, 0,          0, 0,            0,  32'h104,      0, 0, 0, 32'h104,      32'h0,     16'd2);
    vecs[10] = mk(0, 1, 0, 0, 0,          1, 32'h600,      1,  EXC,          1, 1, 1, EXC,          32'h104,   16'd3);
    // buffered jump: three busy cycles, accepted on the fourth edge
    vecs[11] = mk(0, 0, 0, 0, 0,          1, 32'h200,      0,  EXC,          0, 1, 0, EXC,          32'h104,   16'd4);
    vecs[12] = mk(0, 0, 1, 0, 0,          1, 32'h200,      0,  EXC,          0, 0, 0, EXC,          32'h104,   16'd4);
    vecs[13] = mk(0, 0, 0, 1, 32'h700,    1, 32'h200,      0,  EXC,          0, 0, 0, EXC,          32'h104,   16'd4);
    vecs[14] = mk(0, 1, 0, 0, 0,          0, 0,            0,  32'h200,      1, 0, 0, 32'h200,      32'h104,   16'd4);
    // exception while a target is pending
    vecs[15] = mk(0, 0, 0, 1, 32'h300,    0, 0,            0,  32'h200,      0, 1, 1, 32'h200,      32'h104,   16'd5);
    vecs[16] = mk(0, 0, 0, 0, 0,          0, 0,            1,  32'h200,      0, 1, 1, 32'h200,      32'h300,   16'd6);
    vecs[17] = mk(0, 1, 0, 0, 0,          0, 0,            0,  EXC,          1, 0, 0, EXC,          32'h300,   16'd6);
    vecs[18] = mk(0, 0, 0, 0, 0,          1, 32'h310,      0,  EXC,          0, 1, 0, EXC,          32'h300,   16'd7);
    vecs[19] = mk(0, 1, 0, 0, 0,          0, 0,            1,  EXC,          1, 1, 1, EXC,          32'h310,   16'd8);
    // wrap and alignment
    vecs[20] = mk(0, 1, 0, 0, 0,          1, 32'hFFFF_FFFC,0,  32'hFFFF_FFFC,1, 1, 0, 32'hFFFF_FFFC,32'h310,   16'd9);
    vecs[21] = mk(0, 1, 0, 0, 0,          0, 0,            0,  32'h0,        1, 0, 0, 32'h0,        32'h310,   16'd9);
    vecs[22] = mk(0, 1, 0, 0, 0,          1, 32'h123,      0,  32'h120,      1, 1, 0, 32'h120,      32'h310,   16'd10);
    // reset while pending
    vecs[23] = mk(0, 0, 0, 0, 0,          1, 32'h500,      0,  32'h120,      0, 1, 0, 32'h120,      32'h310,   16'd11);
    vecs[24] = mk(1, 1, 0, 0, 0,          0, 0,            0,  32'h0,        0, 0, 0, 32'h120,      32'h0,     16'd0);
    vecs[25] = mk(0, 1, 0, 0, 0,          0, 0,            0,  32'h0,        1, 0, 0, 32'h0,        32'h0,     16'd0);
    vecs[26] = mk(0, 1, 0, 0, 0,          0, 0,            0,  32'h4,        1, 0, 0, 32'h4,        32'h0,     16'd0);

    @(posedge CLK); #1;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].stall, vecs[i].br, vecs[i].bt,
            vecs[i].jmp, vecs[i].jt, vecs[i].exc);
      @(negedge CLK);
      chk("PC_Next",  i, PC_Next,         vecs[i].pn);
      chk("w_en",     i, 32'(w_en),       32'(vecs[i].we));
      chk("flush_if", i, 32'(flush_if),   32'(vecs[i].fi));
      chk("flush_id", i, 32'(flush_id),   32'(vecs[i].fd));
      @(posedge CLK); #1;
      chk("pc",       i, PCResult,        vecs[i].pc);
      chk("epc",      i, epc,             vecs[i].ep);
      chk("count",    i, 32'(redirect_count), 32'(vecs[i].cnt));
    end

    // Long busy window: one accepted write per redirect, target lands once ready.
    pulses = 0;
    drive(0, 0, 0, 1, 32'h1F0, 0, 0, 0);
    @(negedge CLK); if (w_en) pulses++;
    @(posedge CLK); #1;
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, k[0], ~k[0], 32'h2A0, k[1], 32'h2B0, 0);
      @(negedge CLK); if (w_en) pulses++;
      @(posedge CLK); #1;
    end
    chk("busy_no_write", 0, 32'(pulses), 32'd0);
    chk("busy_pc_hold",  0, PCResult,    32'h4);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    waited = 0;
    while (PCResult !== 32'h1F0 && waited < 20) begin
      if (waited == 3) imem_ready = 1'b1;
      @(negedge CLK); if (w_en) pulses++;
      @(posedge CLK); #1;
      waited++;
    end
    chk("pend_arrive",   waited, PCResult,    32'h1F0);
    chk("pend_latency",  0, 32'(waited), 32'd4);
    chk("pend_pulses",   0, 32'(pulses), 32'd1);
    chk("pend_count",    0, 32'(redirect_count), 32'd1);
    imem_ready = 1'b0;
    @(negedge CLK);
    chk("pend_back_run", 0, {PC_Next[31:1], w_en}, {32'h1F0 >> 1, 1'b0} | 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
